// File: rtl/result_matrix_store.sv
// Register-file store for the m x m result matrix Z: accepts strobed result writes,
// returns Z[z_i][z_j] for accumulation, and supports a zeroing pass and a row-major dump.
module result_matrix_store #(
  parameter int m     = 4,
  parameter int m_len = (m > 1) ? $clog2(m) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  output logic              busy,
  input  logic [31:0]       z_out,
  input  logic [m_len-1:0]  z_i,
  input  logic [m_len-1:0]  z_j,
  input  logic              z_stb,
  output logic              z_ack,
  output logic [31:0]       current_element,
  input  logic              dump_start,
  output logic [31:0]       dout,
  output logic [m_len-1:0]  dout_i,
  output logic [m_len-1:0]  dout_j,
  output logic              dout_valid,
  input  logic              dout_ready,
  output logic              dump_done,
  output logic [15:0]       write_count
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACK   = 2'd1,
    S_CLEAR = 2'd2,
    S_DUMP  = 2'd3
  } state_t;

  localparam logic [m_len-1:0] LAST = m_len'(m - 1);

  state_t           state;
  logic [31:0]      z_mem [m][m];
  logic [m_len-1:0] clr_i, clr_j;
  logic [m_len-1:0] nxt_i, nxt_j;
  logic             in_range;

  assign in_range = (int'(z_i) < m) && (int'(z_j) < m);

  // Out-of-range coordinates read as zero so accumulation never sees stale data.
  always_comb begin
    current_element = '0;
    if (in_range) current_element = z_mem[z_i][z_j];
  end

  always_comb begin
    nxt_i = dout_i;
    nxt_j = dout_j + 1'b1;
    if (dout_j == LAST) begin
      nxt_j = '0;
      nxt_i = dout_i + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < m; i++)
        for (int j = 0; j < m; j++)
          z_mem[i][j] <= '0;
      state       <= S_IDLE;
      z_ack       <= 1'b0;
      busy        <= 1'b0;
      dout        <= '0;
      dout_i      <= '0;
      dout_j      <= '0;
      dout_valid  <= 1'b0;
      dump_done   <= 1'b0;
      write_count <= '0;
      clr_i       <= '0;
      clr_j       <= '0;
    end else begin
      dump_done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (clear) begin
            state       <= S_CLEAR;
            busy        <= 1'b1;
            clr_i       <= '0;
            clr_j       <= '0;
            write_count <= '0;
          end else if (z_stb) begin
            if (in_range) z_mem[z_i][z_j] <= z_out;
            write_count <= write_count + 16'd1;
            z_ack       <= 1'b1;
            state       <= S_ACK;
          end else if (dump_start) begin
            state      <= S_DUMP;
            busy       <= 1'b1;
            dout       <= z_mem[0][0];
            dout_i     <= '0;
            dout_j     <= '0;
            dout_valid <= 1'b1;
          end
        end
        // Hold the ack until the producer drops its strobe: one write per handshake.
        S_ACK: begin
          if (!z_stb) begin
            z_ack <= 1'b0;
            state <= S_IDLE;
          end
        end
        S_CLEAR: begin
          z_mem[clr_i][clr_j] <= '0;
          if (clr_j == LAST) begin
            clr_j <= '0;
            if (clr_i == LAST) begin
              clr_i <= '0;
              busy  <= 1'b0;
              state <= S_IDLE;
            end else begin
              clr_i <= clr_i + 1'b1;
            end
          end else begin
            clr_j <= clr_j + 1'b1;
          end
        end
        S_DUMP: begin
          if (dout_valid && dout_ready) begin
            if (dout_i == LAST && dout_j == LAST) begin
              dout_valid <= 1'b0;
              dump_done  <= 1'b1;
              busy       <= 1'b0;
              state      <= S_IDLE;
            end else begin
              dout_i <= nxt_i;
              dout_j <= nxt_j;
              dout   <= z_mem[nxt_i][nxt_j];
            end
          end
        end
        default: begin
          state      <= S_IDLE;
          z_ack      <= 1'b0;
          busy       <= 1'b0;
          dout_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_result_matrix_store.sv
// Directed + randomized bench for result_matrix_store against a plain array model of Z.
module tb_result_matrix_store;
  localparam int M = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        clear, z_stb, dump_start, dout_ready;
  logic [31:0] z_out;
  logic [1:0]  z_i, z_j;
  logic        busy, z_ack, dout_valid, dump_done;
  logic [31:0] current_element, dout;
  logic [1:0]  dout_i, dout_j;
  logic [15:0] write_count;

  logic        c3_clear, c3_stb, c3_dump_start, c3_ready;
  logic [31:0] c3_out;
  logic [1:0]  c3_i, c3_j;
  logic        c3_busy, c3_ack, c3_valid, c3_done;
  logic [31:0] c3_cur, c3_dout;
  logic [1:0]  c3_dout_i, c3_dout_j;
  logic [15:0] c3_wcount;

  int          tests = 0;
  int          fails = 0;
  logic [31:0] model [M][M];
  logic [15:0] wcount;

  always #5 clk = ~clk;

  result_matrix_store #(.m(4)) u_dut (
    .clk(clk), .rst(rst), .clear(clear), .busy(busy), .z_out(z_out), .z_i(z_i), .z_j(z_j),
    .z_stb(z_stb), .z_ack(z_ack), .current_element(current_element), .dump_start(dump_start),
    .dout(dout), .dout_i(dout_i), .dout_j(dout_j), .dout_valid(dout_valid),
    .dout_ready(dout_ready), .dump_done(dump_done), .write_count(write_count)
  );

  result_matrix_store #(.m(3)) u_dut3 (
    .clk(clk), .rst(rst), .clear(c3_clear), .busy(c3_busy), .z_out(c3_out), .z_i(c3_i),
    .z_j(c3_j), .z_stb(c3_stb), .z_ack(c3_ack), .current_element(c3_cur),
    .dump_start(c3_dump_start), .dout(c3_dout), .dout_i(c3_dout_i), .dout_j(c3_dout_j),
    .dout_valid(c3_valid), .dout_ready(c3_ready), .dump_done(c3_done), .write_count(c3_wcount)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < M; i++)
      for (int j = 0; j < M; j++)
        model[i][j] = '0;
    wcount = '0;
  endtask

  task automatic check_all(input string tag);
    for (int i = 0; i < M; i++)
      for (int j = 0; j < M; j++) begin
        z_i = 2'(i);
        z_j = 2'(j);
        #1;
        check(tag, current_element, model[i][j]);
      end
    check({tag, "_wcount"}, 32'(write_count), 32'(wcount));
  endtask

  task automatic do_write(input int i, input int j, input logic [31:0] v);
    int n;
    z_i = 2'(i); z_j = 2'(j); z_out = v; z_stb = 1'b1;
    n = 0;
    do begin tick(); n++; end while (!z_ack && n < 60);
    check("ack_seen", 32'(z_ack), 32'd1);
    z_stb = 1'b0;
    tick();
    check("ack_drop", 32'(z_ack), 32'd0);
    model[i][j] = v;
    wcount = wcount + 16'd1;
  endtask

  task automatic run_dump(input bit rand_rdy, input bit poke_stb);
    int k, cyc;
    dump_start = 1'b1;
    tick();
    dump_start = 1'b0;
    if (poke_stb) begin
      z_i = 2'd0; z_j = 2'd0; z_out = 32'hDEADBEEF; z_stb = 1'b1;
    end
    k = 0; cyc = 0;
    while (k < M*M && cyc < 300) begin
      check("dump_valid", 32'(dout_valid), 32'd1);
      check("dout", dout, model[k/M][k%M]);
      check("dout_ij", {28'd0, dout_i, dout_j}, 32'((k/M)*4 + (k%M)));
      check("dump_done_early", 32'(dump_done), 32'd0);
      if (poke_stb) check("ack_in_dump", 32'(z_ack), 32'd0);
      dout_ready = rand_rdy ? 1'($urandom_range(0, 1)) : (cyc % 2 == 0);
      if (dout_ready) k++;
      tick();
      cyc++;
    end
    dout_ready = 1'b0;
    check("dump_count", 32'(k), 32'(M*M));
    check("dump_done", 32'(dump_done), 32'd1);
    check("dump_valid_end", 32'(dout_valid), 32'd0);
    if (poke_stb) begin
      do_write(0, 0, 32'hDEADBEEF);
    end else begin
      tick();
      check("dump_done_pulse", 32'(dump_done), 32'd0);
      check("busy_after_dump", 32'(busy), 32'd0);
    end
  endtask

  initial begin
    int n;
    logic [31:0] v;
    rst = 1'b1;
    clear = 0; z_stb = 0; dump_start = 0; dout_ready = 0; z_out = 0; z_i = 0; z_j = 0;
    c3_clear = 0; c3_stb = 0; c3_dump_start = 0; c3_ready = 0; c3_out = 0; c3_i = 0; c3_j = 0;
    model_reset();
    tick(); tick();
    rst = 1'b0;
    tick();

    // reset state
    z_i = 2'd2; z_j = 2'd3; #1;
    check("rst_cur", current_element, 32'd0);
    check("rst_wcount", 32'(write_count), 32'd0);
    check("rst_ack", 32'(z_ack), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_valid", 32'(dout_valid), 32'd0);

    // single write, strobe held 5 cycles
    z_i = 2'd1; z_j = 2'd2; z_out = 32'h3F800000; z_stb = 1'b1;
    #1;
    check("ack_pre", 32'(z_ack), 32'd0);
    tick();
    check("ack_rise", 32'(z_ack), 32'd1);
    for (int c = 0; c < 4; c++) begin
      tick();
      check("ack_hold", 32'(z_ack), 32'd1);
    end
    z_stb = 1'b0;
    tick();
    check("ack_fall", 32'(z_ack), 32'd0);
    model[1][2] = 32'h3F800000;
    wcount = 16'd1;
    check_all("single_write");

    // fill, then clear
    for (int i = 0; i < M; i++)
      for (int j = 0; j < M; j++)
        do_write(i, j, 32'(16*i + j));
    check_all("fill");
    clear = 1'b1;
    tick();
    clear = 1'b0;
    n = 0;
    while (busy && n < 40) begin n++; tick(); end
    check("clear_busy_cycles", 32'(n), 32'd16);
    model_reset();
    check_all("after_clear");

    // randomized writes and reads
    for (int t = 0; t < 24; t++)
      do_write(int'($urandom_range(0, M-1)), int'($urandom_range(0, M-1)), $urandom);
    check_all("rand_write");

    run_dump(1'b0, 1'b0);
    run_dump(1'b1, 1'b1);
    check_all("after_dump");

    // clear, z_stb and dump_start together
    v = $urandom;
    clear = 1'b1; dump_start = 1'b1; z_stb = 1'b1; z_i = 2'd0; z_j = 2'd1; z_out = v;
    tick();
    clear = 1'b0; dump_start = 1'b0;
    check("simul_busy", 32'(busy), 32'd1);
    check("simul_noack", 32'(z_ack), 32'd0);
    n = 1;
    while (!z_ack && n < 50) begin tick(); n++; end
    check("simul_ack_delay", 32'(n), 32'd18);
    z_stb = 1'b0;
    tick();
    check("simul_ack_drop", 32'(z_ack), 32'd0);
    check("simul_no_dump", 32'(dout_valid), 32'd0);
    model_reset();
    model[0][1] = v;
    wcount = 16'd1;
    check_all("simul");

    // reset in the middle of a dump
    for (int t = 0; t < 6; t++)
      do_write(int'($urandom_range(0, M-1)), int'($urandom_range(0, M-1)), $urandom | 32'h1);
    dump_start = 1'b1;
    tick();
    dump_start = 1'b0;
    dout_ready = 1'b1;
    n = 0;
    while (n < 5) begin tick(); n++; end
    check("abort_pos", {28'd0, dout_i, dout_j}, 32'd5);
    check("abort_word", dout, model[1][1]);
    dout_ready = 1'b0;
    rst = 1'b1;
    tick();
    check("abort_valid", 32'(dout_valid), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    rst = 1'b0;
    tick();
    model_reset();
    check_all("after_abort");

    // m = 3: out-of-range write is acked but stores nothing
    c3_i = 2'd3; c3_j = 2'd3; c3_out = 32'hCAFEF00D; c3_stb = 1'b1;
    tick();
    check("m3_ack", 32'(c3_ack), 32'd1);
    c3_stb = 1'b0;
    tick();
    check("m3_ack_drop", 32'(c3_ack), 32'd0);
    check("m3_wcount", 32'(c3_wcount), 32'd1);
    check("m3_oob_read", c3_cur, 32'd0);
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++) begin
        c3_i = 2'(i); c3_j = 2'(j); #1;
        check("m3_cells", c3_cur, 32'd0);
      end
    c3_i = 2'd2; c3_j = 2'd2; c3_out = 32'h12345678; c3_stb = 1'b1;
    tick();
    c3_stb = 1'b0;
    tick();
    check("m3_write", c3_cur, 32'h12345678);
    check("m3_wcount2", 32'(c3_wcount), 32'd2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
